vector_collector: RTL and testbench

VECTOR_COLLECTOR -- requirements
Module: vector_collector

---
 rtl/vector_collector.sv | 172 +++++++++++++++++
 tb/tb_vector_collector.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_collector.sv
// ---------------------------------------------------------------------------
// vector_collector
//
// Gathers M consecutive IEEE-754 single-precision scalars from a stb/ack
// upstream into one M-element vector and presents the whole vector to a
// stb/ack downstream. An optional ReLU stage clamps any sign-set word
// (negative numbers, -0.0, -inf, sign-set NaN) to +0.0 on the way in.
//
// Parameters
//   M     vector length, 1..256
//   RELU  1: clamp sign-set inputs to 32'h00000000, 0: store inputs unchanged
//
// Ports
//   clk           single clock, all state changes on its rising edge
//   rst           synchronous, active-low reset
//   input_a       scalar word from upstream
//   input_a_stb   upstream word valid
//   input_a_ack   this block accepts input_a (registered)
//   output_z      collected vector, element k in output_z[k] (registered)
//   output_z_stb  output_z holds a complete vector (registered)
//   output_z_ack  downstream accepts output_z
// ---------------------------------------------------------------------------
module vector_collector #(
    parameter int M    = 8,
    parameter int RELU = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         input_a,
    input  logic                input_a_stb,
    output logic                input_a_ack,
    output logic [M-1:0][31:0]  output_z,
    output logic                output_z_stb,
    input  logic                output_z_ack
);

    // One index bit minimum so that M=1 still has a legal counter.
    localparam int              IDXW     = (M > 1) ? $clog2(M) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDXW-1:0]    r_idx;
    logic [IDXW-1:0]    w_idx_next;
    logic               r_ack;
    logic               w_ack_next;
    logic               r_stb;
    logic               w_stb_next;
    logic [M-1:0][31:0] r_vec;

    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_last;
    logic [31:0]        w_proc;
    logic [M-1:0]       w_wr_en;

    // Transfers are qualified by the registered handshake outputs, so an
    // input strobe during OUTPUT (ack low) can never be consumed.
    assign w_in_xfer  = input_a_stb & r_ack & (r_state == S_COLLECT);
    assign w_out_xfer = output_z_ack & r_stb & (r_state == S_OUTPUT);
    assign w_last     = (r_idx == LAST_IDX);

    // ReLU works purely on the sign bit: every sign-set encoding becomes +0.0,
    // everything else passes bit-exact (including positive NaNs).
    generate
        if (RELU != 0) begin : g_relu
            assign w_proc = input_a[31] ? 32'h0000_0000 : input_a;
        end else begin : g_bypass
            assign w_proc = input_a;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_ack_next   = r_ack;
        w_stb_next   = r_stb;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_COLLECT;
                w_ack_next   = 1'b1;
                w_stb_next   = 1'b0;
            end

            S_COLLECT: begin
                if (w_in_xfer) begin
                    if (w_last) begin
                        // Last element: drop ack and raise stb on the same
                        // edge, so the vector is visible one cycle later.
                        w_idx_next   = '0;
                        w_ack_next   = 1'b0;
                        w_stb_next   = 1'b1;
                        w_state_next = S_OUTPUT;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end

            S_OUTPUT: begin
                if (w_out_xfer) begin
                    w_stb_next   = 1'b0;
                    w_ack_next   = 1'b1;
                    w_state_next = S_COLLECT;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_idx_next   = '0;
                w_ack_next   = 1'b0;
                w_stb_next   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_ack   <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_ack   <= w_ack_next;
            r_stb   <= w_stb_next;
        end
    end

    // ------------------------------------------------------------------
    // Vector storage: one write enable per element, decoded from idx.
    // Elements keep their contents after an output transfer and are only
    // replaced by the next transfer aimed at the same position.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_wr_en
            assign w_wr_en[gi] = w_in_xfer & (r_idx == IDXW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vec <= '0;
        end else begin
            for (int k = 0; k < M; k++) begin
                if (w_wr_en[k]) begin
                    r_vec[k] <= w_proc;
                end
            end
        end
    end

    assign input_a_ack  = r_ack;
    assign output_z_stb = r_stb;
    assign output_z     = r_vec;

endmodule

// File: tb/tb_vector_collector.sv
// ---------------------------------------------------------------------------
// tb_vector_collector
//
// Four collectors share one clock and reset:
//   inst 0: M=4, RELU=1   (driven by channel 0)
//   inst 1: M=4, RELU=0   (also driven by channel 0, same stimulus)
//   inst 2: M=1, RELU=1   (channel 1)
//   inst 3: M=3, RELU=1   (channel 2)
// A transaction-level reference model tracks, per instance, whether it has
// left reset, whether a complete vector is pending, how many words of the
// current vector have arrived, and the expected vector contents.
// ---------------------------------------------------------------------------
module tb_vector_collector;

    localparam int NI = 4;
    localparam int NC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_a    [NC];
    logic        in_stb  [NC];
    logic        out_ack [NC];

    logic        ack_w [NI];
    logic        stb_w [NI];
    logic [3:0][31:0] z0;
    logic [3:0][31:0] z1;
    logic [0:0][31:0] z2;
    logic [2:0][31:0] z3;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit          m_started [NI];
    bit          m_full    [NI];
    bit          m_took    [NI];
    int          m_cnt     [NI];
    int          n_vec     [NI];
    logic [31:0] m_vec     [NI][4];

    always #5 clk = ~clk;

    vector_collector #(.M(4), .RELU(1)) u0 (
        .clk(clk), .rst(rst),
        .input_a(in_a[0]), .input_a_stb(in_stb[0]), .input_a_ack(ack_w[0]),
        .output_z(z0), .output_z_stb(stb_w[0]), .output_z_ack(out_ack[0])
    );
    vector_collector #(.M(4), .RELU(0)) u1 (
        .clk(clk), .rst(rst),
        .input_a(in_a[0]), .input_a_stb(in_stb[0]), .input_a_ack(ack_w[1]),
        .output_z(z1), .output_z_stb(stb_w[1]), .output_z_ack(out_ack[0])
    );
    vector_collector #(.M(1), .RELU(1)) u2 (
        .clk(clk), .rst(rst),
        .input_a(in_a[1]), .input_a_stb(in_stb[1]), .input_a_ack(ack_w[2]),
        .output_z(z2), .output_z_stb(stb_w[2]), .output_z_ack(out_ack[1])
    );
    vector_collector #(.M(3), .RELU(1)) u3 (
        .clk(clk), .rst(rst),
        .input_a(in_a[2]), .input_a_stb(in_stb[2]), .input_a_ack(ack_w[3]),
        .output_z(z3), .output_z_stb(stb_w[3]), .output_z_ack(out_ack[2])
    );

    function automatic int m_of(input int i);
        case (i)
            0, 1:    return 4;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic bit relu_of(input int i);
        return (i != 1);
    endfunction

    function automatic int ch_of(input int i);
        return (i <= 1) ? 0 : i - 1;
    endfunction

    function automatic logic [31:0] proc(input int i, input logic [31:0] a);
        return (relu_of(i) && a[31]) ? 32'h0000_0000 : a;
    endfunction

    function automatic logic [31:0] dut_z(input int i, input int k);
        case (i)
            0:       return z0[k[1:0]];
            1:       return z1[k[1:0]];
            2:       return z2[0];
            default: return z3[k[1:0]];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance the model by one rising edge, using the inputs the bench drives.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            int c;
            c = ch_of(i);
            m_took[i] = 1'b0;
            if (!rst) begin
                m_started[i] = 1'b0;
                m_full[i]    = 1'b0;
                m_cnt[i]     = 0;
                for (int k = 0; k < 4; k++) m_vec[i][k] = 32'h0;
            end else if (!m_started[i]) begin
                m_started[i] = 1'b1;
            end else if (m_full[i]) begin
                if (out_ack[c]) begin
                    m_full[i] = 1'b0;
                    n_vec[i]++;
                    $display("[TB] inst %0d: vector %0d delivered", i, n_vec[i]);
                end
            end else if (in_stb[c]) begin
                m_vec[i][m_cnt[i]] = proc(i, in_a[c]);
                m_took[i] = 1'b1;
                m_cnt[i]++;
                if (m_cnt[i] == m_of(i)) begin
                    m_cnt[i]  = 0;
                    m_full[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("ack%0d", i), 32'(ack_w[i]), 32'(m_started[i] && !m_full[i]));
            check($sformatf("stb%0d", i), 32'(stb_w[i]), 32'(m_full[i]));
            for (int k = 0; k < m_of(i); k++)
                check($sformatf("z%0d_%0d", i, k), dut_z(i, k), m_vec[i][k]);
        end
    endtask

    // One clock: model follows the edge, DUT outputs compared on the falling
    // edge, and the caller changes inputs after that.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Offer one word on channel c after 'gap' idle cycles; waits for the
    // transfer. With rand_ack the downstream ack toggles randomly meanwhile.
    task automatic send(input int c, input logic [31:0] w, input int gap, input bit rand_ack);
        int inst;
        int n;
        inst = (c == 0) ? 0 : c + 1;
        if (gap > 0) begin
            in_stb[c] = 1'b0;
            repeat (gap) begin
                if (rand_ack) out_ack[c] = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        in_a[c]   = w;
        in_stb[c] = 1'b1;
        n = 0;
        do begin
            if (rand_ack) out_ack[c] = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end while (!m_took[inst] && n < 100);
        if (!m_took[inst]) check($sformatf("send_tmo%0d", c), 32'(ack_w[inst]), 32'd1);
    endtask

    initial begin
        logic [31:0] words [4];
        logic [31:0] exp0 [4];
        logic [31:0] rw [4];
        int n_obs;

        for (int c = 0; c < NC; c++) begin
            in_a[c] = 32'h0; in_stb[c] = 1'b0; out_ack[c] = 1'b0;
        end
        rst = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) check("rst_z0", z0[k], 32'h0);

        // leaving reset: COLLECT after the first edge, ack visible right away
        rst = 1'b1;
        tick();
        check("ack_post_rst", 32'(ack_w[0]), 32'd1);

        // basic collect / bypass, strobe held high
        words = '{32'h3F800000, 32'hC0000000, 32'h80000000, 32'h40400000};
        exp0  = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h40400000};
        for (int j = 0; j < 4; j++) send(0, words[j], 0, 1'b0);
        check("basic_stb", 32'(stb_w[0]), 32'd1);
        for (int k = 0; k < 4; k++) check("basic_z", z0[k], exp0[k]);
        check("bypass_z1", z1[1], 32'hC0000000);
        check("bypass_z2", z1[2], 32'h80000000);

        // backpressure: stb stays high with a new word, ack held off 10 cycles
        in_a[0] = 32'h11111111;
        repeat (10) tick();
        check("bp_ack", 32'(ack_w[0]), 32'd0);
        check("bp_z0", z0[0], 32'h3F800000);
        out_ack[0] = 1'b1;
        tick();
        out_ack[0] = 1'b0;
        check("bp_stb_fall", 32'(stb_w[0]), 32'd0);
        check("bp_ack_rise", 32'(ack_w[0]), 32'd1);
        tick();
        check("bp_next_z0", z0[0], 32'h11111111);
        for (int j = 0; j < 3; j++) send(0, $urandom, $urandom_range(0, 3), 1'b0);
        check("bp_vec2_stb", 32'(stb_w[0]), 32'd1);

        // random traffic on the M=4 pair
        for (int j = 0; j < 16; j++) send(0, $urandom, $urandom_range(0, 2), 1'b1);

        // reset mid-vector: drain, send 2 words, reset for one cycle
        out_ack[0] = 1'b1;
        in_stb[0]  = 1'b0;
        repeat (2) tick();
        out_ack[0] = 1'b0;
        send(0, 32'h3F800000, 0, 1'b0);
        send(0, 32'h40000000, 0, 1'b0);
        in_stb[0] = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) check("midrst_z0", z0[k], 32'h0);
        check("midrst_stb", 32'(stb_w[0]), 32'd0);
        tick();
        for (int j = 0; j < 4; j++) begin
            rw[j] = $urandom;
            send(0, rw[j], 0, 1'b0);
        end
        for (int k = 0; k < 4; k++) check("midrst_fill", z0[k], proc(0, rw[k]));
        in_stb[0] = 1'b0;
        out_ack[0] = 1'b1;
        tick();
        out_ack[0] = 1'b0;

        // M=1 with downstream ack tied high: one transfer every two cycles
        out_ack[1] = 1'b1;
        in_a[1]    = $urandom;
        in_stb[1]  = 1'b1;
        n_obs = 0;
        repeat (10) begin
            if (in_stb[1] && ack_w[2]) n_obs++;
            tick();
            if (m_took[2]) in_a[1] = $urandom;
        end
        check("m1_rate", 32'(n_obs), 32'd5);
        in_stb[1] = 1'b0;
        tick();

        // M=3 with random input gaps and random downstream ack
        for (int j = 0; j < 30; j++) send(2, $urandom, $urandom_range(0, 5), 1'b1);
        in_stb[2]  = 1'b0;
        out_ack[2] = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
